strided_rd_stream: RTL and testbench

Parametrised 2-D strided read front end between the Avalon-style burst read master and the compute cores. It fetches `cfg_rows` rows of `cfg_len` words each, with row starts spaced `cfg_stride` bytes apart. Each row is split into bursts of at most `MAXBURST` beats. Each `XDW`-bit beat is unpacked into `DW`-bit words, and the words go through an internal FIFO to a valid/ready stream with a per-row `out_last` marker.

---
 rtl/strided_rd_pkg.sv | 32 +++
 rtl/sync_fifo_fwft.sv | 45 ++++
 rtl/strided_rd_stream.sv | 204 ++++++++++++++++++++
 tb/tb_strided_rd_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strided_rd_pkg.sv
// Shared types and constant helpers for the strided read stream front end.
package strided_rd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_ROWEND,
    S_DRAIN
  } state_t;

  // Output words carried by one read-master beat.
  function automatic int ratio(input int xdw, input int dw);
    return xdw / dw;
  endfunction

  // Bytes carried by one read-master beat.
  function automatic int beat_bytes(input int xdw);
    return xdw / 8;
  endfunction

  // Ceiling log2; used for the beat-to-byte shift and counter widths.
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead FIFO: head entry is visible on o_rdata while not empty.
module sync_fifo_fwft #(
  parameter int W  = 33,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_wr, w_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count = r_wptr - r_rptr;
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (r_wptr == r_rptr);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;

  // Read/write pointers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end

endmodule

// File: rtl/strided_rd_stream.sv
// 2-D strided read front end: issues per-row bursts to the read master,
// unpacks wide beats into words and streams them out with a row-end marker.
module strided_rd_stream
  import strided_rd_pkg::*;
#(
  parameter int XAW      = 32,
  parameter int XDW      = 128,
  parameter int DW       = 32,
  parameter int LW       = 16,
  parameter int CW       = 16,
  parameter int MAXBURST = 32,
  parameter int FAW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [XAW-1:0]  cfg_base,
  input  logic [XAW-1:0]  cfg_stride,
  input  logic [CW-1:0]   cfg_rows,
  input  logic [LW-1:0]   cfg_len,
  output logic            busy,
  output logic            done,
  output logic            rmst_fixed_location,
  output logic [XAW-1:0]  rmst_read_base,
  output logic [XAW-1:0]  rmst_read_length,
  output logic            rmst_go,
  input  logic            rmst_done,
  output logic            rmst_user_read_buffer,
  input  logic [XDW-1:0]  rmst_user_buffer_data,
  input  logic            rmst_user_data_available,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last
);

  localparam int R   = ratio(XDW, DW);
  localparam int BB  = beat_bytes(XDW);
  localparam int BSH = log2c(BB);
  localparam int RW  = log2c(R + 1);

  state_t          r_state, w_state_nxt;

  // Burst/row sequencing
  logic [XAW-1:0]  r_row_base, r_burst_base, r_stride;
  logic [LW-1:0]   r_rem, r_beats;
  logic [CW-1:0]   r_rows_left;
  logic [RW-1:0]   r_tail;

  // Unpacker
  logic [XDW-1:0]  r_sh;
  logic [RW-1:0]   r_wcnt;
  logic            r_lastbeat;
  logic [LW-1:0]   r_ub_rem;
  logic [CW-1:0]   r_ur_rem;

  logic [XAW-1:0]  w_amask, w_step, w_next_row;
  logic [LW:0]     w_len_ext;
  logic [LW-1:0]   w_cfg_beats, w_n, w_rem_nxt;
  logic [RW-1:0]   w_cfg_tail;
  logic            w_zero_job, w_emit, w_pop, w_beat_last, w_all_out;
  logic            w_full, w_empty;
  logic [FAW:0]    w_fifo_cnt;
  logic [DW:0]     w_wdata, w_rdata;

  assign w_amask     = ~XAW'(BB - 1);
  assign w_len_ext   = {1'b0, cfg_len} + (LW+1)'(R - 1);
  assign w_cfg_beats = LW'(w_len_ext / (LW+1)'(R));
  // Words that survive on the final beat of a row: 1..R.
  assign w_cfg_tail  = RW'((cfg_len - LW'(1)) % LW'(R)) + RW'(1);
  assign w_zero_job  = (cfg_rows == '0) || (cfg_len == '0);

  assign w_n         = (r_rem > LW'(MAXBURST)) ? LW'(MAXBURST) : r_rem;
  assign w_step      = XAW'(w_n) << BSH;
  assign w_rem_nxt   = r_rem - w_n;
  assign w_next_row  = r_row_base + r_stride;

  assign rmst_fixed_location = 1'b0;
  assign rmst_read_base      = r_burst_base;
  assign rmst_read_length    = w_step;

  // A beat may only be popped once the current one is used up (or finishes
  // this cycle), so the shift register is reloaded without a bubble.
  assign w_emit      = (r_wcnt != '0) && !w_full;
  assign w_pop       = rmst_user_data_available && (r_ur_rem != '0) &&
                       ((r_wcnt == '0) || ((r_wcnt == RW'(1)) && w_emit));
  assign w_beat_last = (r_ub_rem == LW'(1));
  assign rmst_user_read_buffer = w_pop;

  assign w_wdata   = {r_lastbeat && (r_wcnt == RW'(1)), r_sh[DW-1:0]};
  assign w_all_out = (r_ur_rem == '0) && (r_wcnt == '0) && (w_fifo_cnt == '0);

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_rdata[DW-1:0];
  assign out_last  = !w_empty && w_rdata[DW];

  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cfg_start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = w_zero_job ? S_DRAIN : S_ISSUE;
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT:   if (rmst_done) w_state_nxt = (w_rem_nxt != '0) ? S_ISSUE : S_ROWEND;
      S_ROWEND: w_state_nxt = (r_rows_left > CW'(1)) ? S_ISSUE : S_DRAIN;
      S_DRAIN:  if (w_all_out) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = (r_state != S_IDLE);
    rmst_go = (r_state == S_ISSUE);
    done    = (r_state == S_DRAIN) && w_all_out;
  end

  // Address and burst/row counters; base/length stay put while WAITing.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_row_base   <= '0;
      r_burst_base <= '0;
      r_stride     <= '0;
      r_rem        <= '0;
      r_beats      <= '0;
      r_rows_left  <= '0;
      r_tail       <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_row_base   <= cfg_base & w_amask;
          r_burst_base <= cfg_base & w_amask;
          r_stride     <= cfg_stride & w_amask;
          r_beats      <= w_cfg_beats;
          r_rem        <= w_zero_job ? '0 : w_cfg_beats;
          r_rows_left  <= cfg_rows;
          r_tail       <= w_cfg_tail;
        end
        S_WAIT: if (rmst_done) begin
          r_burst_base <= r_burst_base + w_step;
          r_rem        <= w_rem_nxt;
        end
        S_ROWEND: begin
          r_rows_left <= r_rows_left - CW'(1);
          if (r_rows_left > CW'(1)) begin
            r_row_base   <= w_next_row;
            r_burst_base <= w_next_row;
            r_rem        <= r_beats;
          end
        end
        default: ;
      endcase
    end

  // Unpacker beat/row bookkeeping: tracks how many beats the job still owes.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ub_rem <= '0;
      r_ur_rem <= '0;
    end else if (r_state == S_LOAD) begin
      r_ub_rem <= w_cfg_beats;
      r_ur_rem <= w_zero_job ? '0 : cfg_rows;
    end else if (w_pop) begin
      if (w_beat_last) begin
        r_ub_rem <= r_beats;
        r_ur_rem <= r_ur_rem - CW'(1);
      end else begin
        r_ub_rem <= r_ub_rem - LW'(1);
      end
    end

  // Unpacker shift register: low word first, trimmed on a row's last beat.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sh       <= '0;
      r_wcnt     <= '0;
      r_lastbeat <= 1'b0;
    end else if (w_pop) begin
      r_sh       <= rmst_user_buffer_data;
      r_wcnt     <= w_beat_last ? r_tail : RW'(R);
      r_lastbeat <= w_beat_last;
    end else if (w_emit) begin
      r_sh   <= r_sh >> DW;
      r_wcnt <= r_wcnt - RW'(1);
    end

  sync_fifo_fwft #(.W(DW + 1), .AW(FAW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_emit),
    .i_wdata (w_wdata),
    .i_rd    (out_valid & out_ready),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

endmodule

// File: tb/tb_strided_rd_stream.sv
// Randomised self-checking bench for strided_rd_stream with a behavioural
// read-master model and a queue-based expected-stream model.
module tb_strided_rd_stream;

  localparam int XAW = 32, XDW = 128, DW = 32, LW = 16, CW = 16, MAXB = 32, FAW = 8;
  localparam int R = XDW / DW, BB = XDW / 8;

  logic clk = 1'b0, rst = 1'b0;
  logic cfg_start = 1'b0;
  logic [XAW-1:0] cfg_base = '0, cfg_stride = '0;
  logic [CW-1:0] cfg_rows = '0;
  logic [LW-1:0] cfg_len = '0;
  logic busy, done, rmst_fixed_location, rmst_go, rmst_user_read_buffer;
  logic [XAW-1:0] rmst_read_base, rmst_read_length;
  logic rmst_done = 1'b0, rmst_user_data_available = 1'b0;
  logic [XDW-1:0] rmst_user_buffer_data = '0;
  logic out_valid, out_last;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_data;

  strided_rd_stream #(.XAW(XAW), .XDW(XDW), .DW(DW), .LW(LW), .CW(CW),
                      .MAXBURST(MAXB), .FAW(FAW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_stride(cfg_stride), .cfg_rows(cfg_rows), .cfg_len(cfg_len),
    .busy(busy), .done(done), .rmst_fixed_location(rmst_fixed_location),
    .rmst_read_base(rmst_read_base), .rmst_read_length(rmst_read_length),
    .rmst_go(rmst_go), .rmst_done(rmst_done),
    .rmst_user_read_buffer(rmst_user_read_buffer),
    .rmst_user_buffer_data(rmst_user_buffer_data),
    .rmst_user_data_available(rmst_user_data_available),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // ---- model state ----
  logic [32:0] exp_q[$];        // {last, word}
  logic [63:0] exp_burst_q[$];  // {base, length}
  logic [31:0] gob_q[$], gol_q[$];
  logic [XDW-1:0] bq[$];
  logic [31:0] salt = 32'h0;
  int pops = 0, words_out = 0, lasts_out = 0, done_cnt = 0;
  int ncyc = 0, start_n = 0, last_hs = 0;
  int rdy_pct = 100, avail_pct = 80;
  bit chk_en = 0, exp_zero = 0, first_go = 0, in_burst = 0, go_prev = 0;
  logic [31:0] hold_b, hold_l;

  function automatic logic [31:0] wv(input logic [31:0] a);
    return a ^ salt;
  endfunction

  function automatic logic [XDW-1:0] mk_beat(input logic [31:0] a);
    logic [XDW-1:0] b;
    b = '0;
    for (int k = 0; k < R; k++) b[k*DW +: DW] = wv(a + 32'(4*k));
    return b;
  endfunction

  // ---- read master model: unbounded show-ahead buffer ----
  bit m_act = 0;
  logic m_pop, m_go;
  logic [31:0] m_b, m_l, m_addr;
  int m_left;
  always begin
    @(negedge clk);
    m_pop = rmst_user_read_buffer; m_go = rmst_go;
    m_b = rmst_read_base; m_l = rmst_read_length;
    @(posedge clk); #1;
    rmst_done = 1'b0;
    if (rst) begin
      bq.delete(); m_act = 0;
    end else begin
      if (m_pop) begin
        chk("pop_nonempty", 64'(bq.size() != 0), 1);
        if (bq.size() != 0) begin void'(bq.pop_front()); pops++; end
      end
      if (m_go) begin
        m_act = 1; m_addr = m_b; m_left = int'(m_l) / BB;
        gob_q.push_back(m_b); gol_q.push_back(m_l);
      end else if (m_act) begin
        if (m_left > 0) begin
          if ($urandom_range(0, 99) < avail_pct) begin
            bq.push_back(mk_beat(m_addr)); m_addr += BB; m_left--;
          end
        end else begin
          rmst_done = 1'b1; m_act = 0;
        end
      end
    end
    rmst_user_data_available = (bq.size() != 0) && ($urandom_range(0, 99) < avail_pct);
    rmst_user_buffer_data = (bq.size() != 0) ? bq[0] : '0;
  end

  // ---- sink ready ----
  always begin
    @(posedge clk); #1;
    out_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  // ---- per-cycle compare ----
  logic [63:0] eb;
  logic [32:0] ew;
  always begin
    @(negedge clk);
    ncyc++;
    if (!rst && chk_en) begin
      if (cfg_start && !busy) start_n = ncyc;
      if (rmst_go) begin
        chk("go_width", 64'(go_prev), 0);
        if (first_go) begin chk("first_go_cycle", ncyc, start_n + 2); first_go = 0; end
        chk("go_expected", 64'(exp_burst_q.size() != 0), 1);
        if (exp_burst_q.size() != 0) begin
          eb = exp_burst_q.pop_front();
          chk("go_base", rmst_read_base, eb[63:32]);
          chk("go_len", rmst_read_length, eb[31:0]);
        end
        hold_b = rmst_read_base; hold_l = rmst_read_length; in_burst = 1;
      end else if (in_burst) begin
        chk("hold_base", rmst_read_base, hold_b);
        chk("hold_len", rmst_read_length, hold_l);
        if (rmst_done) in_burst = 0;
      end
      go_prev = rmst_go;
      if (out_valid && out_ready) begin
        chk("word_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          ew = exp_q.pop_front();
          chk("out_data", out_data, ew[31:0]);
          chk("out_last", out_last, ew[32]);
        end
        words_out++; lasts_out += int'(out_last); last_hs = ncyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_words_left", exp_q.size(), 0);
        if (exp_zero) chk("done_zero_cycle", ncyc, start_n + 2);
        else          chk("done_cycle", ncyc, last_hs + 1);
      end
    end else begin
      go_prev = 0; in_burst = 0;
    end
  end

  // ---- job helpers ----
  task automatic start_job(input logic [31:0] b, input logic [31:0] s, input int rows, input int len);
    logic [31:0] ab, as, rb, a;
    int rem, n;
    salt = $urandom();
    exp_q.delete(); exp_burst_q.delete(); gob_q.delete(); gol_q.delete();
    words_out = 0; lasts_out = 0; pops = 0;
    ab = b & ~32'(BB - 1); as = s & ~32'(BB - 1);
    exp_zero = (rows == 0) || (len == 0);
    for (int r = 0; r < rows; r++) begin
      rb = ab + 32'(r) * as;
      for (int w = 0; w < len; w++)
        exp_q.push_back({(w == len - 1), wv(rb + 32'(4*w))});
      rem = (len + R - 1) / R; a = rb;
      while (rem > 0) begin
        n = (rem > MAXB) ? MAXB : rem;
        exp_burst_q.push_back({a, 32'(n * BB)});
        a += 32'(n * BB); rem -= n;
      end
    end
    first_go = !exp_zero;
    @(posedge clk); #1;
    cfg_base = b; cfg_stride = s; cfg_rows = CW'(rows); cfg_len = LW'(len); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(posedge clk); #1;
    cfg_base = $urandom(); cfg_stride = $urandom(); cfg_rows = '1; cfg_len = '1;
  endtask

  task automatic wait_done(input int maxc);
    int d0, c;
    d0 = done_cnt; c = 0;
    while (done_cnt == d0 && c < maxc) begin @(posedge clk); c++; end
    chk("done_seen", 64'(done_cnt != d0), 1);
    @(negedge clk);
    chk("bursts_all_issued", exp_burst_q.size(), 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fixed"}, rmst_fixed_location, 0);
    chk({tag, "_go"}, rmst_go, 0);
    chk({tag, "_rbase"}, rmst_read_base, 0);
    chk({tag, "_rlen"}, rmst_read_length, 0);
    chk({tag, "_rdbuf"}, rmst_user_read_buffer, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  initial begin
    int c, rows, len;
    #1 rst = 1'b1;
    #20 chk_outputs_zero("reset");
    @(negedge clk); rst = 1'b0; chk_en = 1;

    // Simple row
    start_job(32'h100, 32'h0, 1, 8); wait_done(2000);
    chk("t1_go_count", gob_q.size(), 1);
    if (gob_q.size() >= 1) begin chk("t1_go_base", gob_q[0], 32'h100); chk("t1_go_len", gol_q[0], 32); end
    chk("t1_words", words_out, 8); chk("t1_lasts", lasts_out, 1);

    // Partial last beat
    start_job(32'h0, 32'h0, 1, 10); wait_done(2000);
    if (gol_q.size() >= 1) chk("t2_go_len", gol_q[0], 48);
    chk("t2_words", words_out, 10); chk("t2_lasts", lasts_out, 1);

    // Burst split
    start_job(32'h0, 32'h0, 1, 200); wait_done(4000);
    chk("t3_go_count", gob_q.size(), 2);
    if (gob_q.size() >= 2) begin
      chk("t3_go0_base", gob_q[0], 32'h0);   chk("t3_go0_len", gol_q[0], 512);
      chk("t3_go1_base", gob_q[1], 32'h200); chk("t3_go1_len", gol_q[1], 288);
    end
    chk("t3_words", words_out, 200);

    // Strided rows
    start_job(32'h100, 32'h1000, 3, 4); wait_done(2000);
    chk("t4_go_count", gob_q.size(), 3);
    if (gob_q.size() >= 3) begin
      chk("t4_base0", gob_q[0], 32'h100); chk("t4_base1", gob_q[1], 32'h1100);
      chk("t4_base2", gob_q[2], 32'h2100);
    end
    chk("t4_words", words_out, 12); chk("t4_lasts", lasts_out, 3);

    // Backpressure: 256 words in FIFO plus one beat held in the unpacker
    rdy_pct = 0;
    start_job(32'h0, 32'h0, 1, 400);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("bp_beats_popped", pops, 65);
    chk("bp_valid", out_valid, 1);
    chk("bp_rdbuf_low", rmst_user_read_buffer, 0);
    chk("bp_words_out", words_out, 0);
    rdy_pct = 100;
    wait_done(5000);
    chk("bp_words", words_out, 400);

    // Zero-size jobs
    start_job(32'h40, 32'h0, 2, 0); wait_done(50);
    chk("z1_no_go", gob_q.size(), 0);
    start_job(32'h40, 32'h10, 0, 5); wait_done(50);
    chk("z2_no_go", gob_q.size(), 0);

    // Reset mid-burst
    rdy_pct = 50;
    start_job(32'h0, 32'h0, 1, 200);
    c = 0;
    while (gob_q.size() == 0 && c < 200) begin @(posedge clk); c++; end
    chk("rst_go_seen", 64'(gob_q.size() != 0), 1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1; chk_en = 0;
    #1 chk_outputs_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst = 1'b0; exp_q.delete(); exp_burst_q.delete(); chk_en = 1;

    // Restart after reset
    start_job(32'h3008, 32'h0233, 2, 37); wait_done(4000);
    chk("after_rst_words", words_out, 74); chk("after_rst_lasts", lasts_out, 2);

    // Random jobs
    for (int j = 0; j < 10; j++) begin
      rows = $urandom_range(1, 4); len = $urandom_range(1, 150);
      rdy_pct = $urandom_range(30, 100); avail_pct = $urandom_range(40, 100);
      start_job($urandom_range(0, 32'hFFFF), $urandom_range(0, 32'h3000), rows, len);
      wait_done(20000);
      chk("rnd_words", words_out, rows * len);
      chk("rnd_lasts", lasts_out, rows);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
